regbus_arbiter: RTL and testbench

REGBUS_ARBITER -- requirements
Module: regbus_arbiter

---
 rtl/regbus_arbiter_if.sv | 34 +++
 rtl/regbus_arbiter.sv | 158 +++++++++++++++
 tb/tb_regbus_arbiter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/regbus_arbiter_if.sv
// Two-master register bus plus the shared slave port. The arbiter takes the
// slave modport; the bench (masters and slave model) takes the master modport.
interface regbus_arbiter_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 16
);
    logic [ADDR_W:1]   m0_addr,   m1_addr;
    logic [DATA_W-1:0] m0_wrdata, m1_wrdata;
    logic              m0_rdmem,  m0_wrmem,  m1_rdmem,  m1_wrmem;
    logic [DATA_W-1:0] m0_rddata, m1_rddata;
    logic              m0_rddone, m0_wrdone, m0_err;
    logic              m1_rddone, m1_wrdone, m1_err;
    logic [ADDR_W:1]   s_addr;
    logic [DATA_W-1:0] s_wrdata,  s_rddata;
    logic              s_rdmem,   s_wrmem,   s_rddone,  s_wrdone;

    modport slave (
        input  m0_addr, m0_wrdata, m0_rdmem, m0_wrmem,
        input  m1_addr, m1_wrdata, m1_rdmem, m1_wrmem,
        output m0_rddata, m0_rddone, m0_wrdone, m0_err,
        output m1_rddata, m1_rddone, m1_wrdone, m1_err,
        output s_addr, s_wrdata, s_rdmem, s_wrmem,
        input  s_rddata, s_rddone, s_wrdone
    );

    modport master (
        output m0_addr, m0_wrdata, m0_rdmem, m0_wrmem,
        output m1_addr, m1_wrdata, m1_rdmem, m1_wrmem,
        input  m0_rddata, m0_rddone, m0_wrdone, m0_err,
        input  m1_rddata, m1_rddone, m1_wrdone, m1_err,
        input  s_addr, s_wrdata, s_rdmem, s_wrmem,
        output s_rddata, s_rddone, s_wrdone
    );
endinterface

// File: rtl/regbus_arbiter.sv
// Round-robin arbiter of two register-bus masters onto one slave, one
// transaction outstanding, with a WAIT timeout that completes with err.

// One pending-request slot per master; a write wins over a simultaneous read.
module regbus_slot #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdmem,
    input  logic              wrmem,
    input  logic [ADDR_W:1]   addr,
    input  logic [DATA_W-1:0] wrdata,
    input  logic              clr,
    output logic              pend,
    output logic              is_wr,
    output logic [ADDR_W:1]   addr_q,
    output logic [DATA_W-1:0] wrdata_q
);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend     <= 1'b0;
            is_wr    <= 1'b0;
            addr_q   <= '0;
            wrdata_q <= '0;
        end else if (clr) begin
            pend <= 1'b0;
        end else if ((rdmem || wrmem) && !pend) begin
            pend     <= 1'b1;
            is_wr    <= wrmem;
            addr_q   <= addr;
            wrdata_q <= wrdata;
        end
    end
endmodule

module regbus_arbiter #(
    parameter int ADDR_W  = 19,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    regbus_arbiter_if.slave   bus
);
    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t                   state, state_nxt;
    logic [1:0]               m_rdmem, m_wrmem, pend, is_wr, clr;
    logic [1:0][ADDR_W:1]     m_addr, slot_addr;
    logic [1:0][DATA_W-1:0]   m_wrdata, slot_wrdata, rddata_q;
    logic [1:0]               rddone_q, wrdone_q, err_q;
    logic                     gnt, gnt_nxt, last_gnt, s_is_wr;
    logic [ADDR_W:1]          s_addr_q;
    logic [DATA_W-1:0]        s_wrdata_q;
    logic [CNT_W-1:0]         cnt;
    logic                     ack_hit, timed_out, finish;

    assign m_rdmem  = {bus.m1_rdmem,  bus.m0_rdmem};
    assign m_wrmem  = {bus.m1_wrmem,  bus.m0_wrmem};
    assign m_addr   = {bus.m1_addr,   bus.m0_addr};
    assign m_wrdata = {bus.m1_wrdata, bus.m0_wrdata};

    for (genvar i = 0; i < 2; i++) begin : g_slot
        regbus_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .rdmem    (m_rdmem[i]),
            .wrmem    (m_wrmem[i]),
            .addr     (m_addr[i]),
            .wrdata   (m_wrdata[i]),
            .clr      (clr[i]),
            .pend     (pend[i]),
            .is_wr    (is_wr[i]),
            .addr_q   (slot_addr[i]),
            .wrdata_q (slot_wrdata[i])
        );
    end

    // Timeout is decided in the cycle the counter equals TIMEOUT, so an ack
    // arriving in that same cycle still wins.
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        clr       = '0;
        finish    = 1'b0;
        ack_hit   = s_is_wr ? bus.s_wrdone : bus.s_rddone;
        timed_out = (cnt == CNT_W'(TIMEOUT));
        case (state)
            IDLE: if (|pend) begin
                state_nxt = ISSUE;
                gnt_nxt   = (&pend) ? ~last_gnt : pend[1];
            end
            ISSUE: state_nxt = WAIT;
            WAIT: if (ack_hit || timed_out) begin
                finish    = 1'b1;
                clr[gnt]  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            gnt        <= 1'b0;
            last_gnt   <= 1'b1;
            s_is_wr    <= 1'b0;
            s_addr_q   <= '0;
            s_wrdata_q <= '0;
            cnt        <= '0;
            rddone_q   <= '0;
            wrdone_q   <= '0;
            err_q      <= '0;
            rddata_q   <= '0;
        end else begin
            state    <= state_nxt;
            rddone_q <= '0;
            wrdone_q <= '0;
            err_q    <= '0;
            cnt      <= (state == WAIT) ? cnt + 1'b1 : '0;
            // Slave address/data latched at grant and held until the next grant.
            if (state == IDLE && |pend) begin
                gnt        <= gnt_nxt;
                s_is_wr    <= is_wr[gnt_nxt];
                s_addr_q   <= slot_addr[gnt_nxt];
                s_wrdata_q <= slot_wrdata[gnt_nxt];
            end
            if (finish) begin
                last_gnt   <= gnt;
                err_q[gnt] <= !ack_hit;
                if (s_is_wr) begin
                    wrdone_q[gnt] <= 1'b1;
                end else begin
                    rddone_q[gnt] <= 1'b1;
                    rddata_q[gnt] <= ack_hit ? bus.s_rddata : '0;
                end
            end
        end
    end

    assign bus.s_addr    = s_addr_q;
    assign bus.s_wrdata  = s_wrdata_q;
    assign bus.s_rdmem   = (state == ISSUE) && !s_is_wr;
    assign bus.s_wrmem   = (state == ISSUE) &&  s_is_wr;
    assign bus.m0_rddata = rddata_q[0];
    assign bus.m1_rddata = rddata_q[1];
    assign bus.m0_rddone = rddone_q[0];
    assign bus.m1_rddone = rddone_q[1];
    assign bus.m0_wrdone = wrdone_q[0];
    assign bus.m1_wrdone = wrdone_q[1];
    assign bus.m0_err    = err_q[0];
    assign bus.m1_err    = err_q[1];
endmodule

// File: tb/tb_regbus_arbiter.sv
// Directed bench for regbus_arbiter: outputs sampled and inputs driven on the
// falling edge; cycle 0 is the first cycle after reset release.
module tb_regbus_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    regbus_arbiter_if #(.ADDR_W(19), .DATA_W(16)) bus ();

    regbus_arbiter #(.ADDR_W(19), .DATA_W(16), .TIMEOUT(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nx(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic quiet();
        bus.m0_rdmem = 1'b0; bus.m0_wrmem = 1'b0;
        bus.m1_rdmem = 1'b0; bus.m1_wrmem = 1'b0;
        bus.s_rddone = 1'b0; bus.s_wrdone = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_s"},    32'({bus.s_rdmem, bus.s_wrmem, bus.s_wrdata}), 32'h0);
        chk({tag, "_sadr"}, 32'(bus.s_addr), 32'h0);
        chk({tag, "_m0"},   32'({bus.m0_rddone, bus.m0_wrdone, bus.m0_err, bus.m0_rddata}), 32'h0);
        chk({tag, "_m1"},   32'({bus.m1_rddone, bus.m1_wrdone, bus.m1_err, bus.m1_rddata}), 32'h0);
    endtask

    task automatic do_reset();
        quiet();
        rst_n = 1'b0;
        nx(2);
        chk_zero("rst");
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.m0_addr = '0; bus.m0_wrdata = '0; bus.m1_addr = '0; bus.m1_wrdata = '0;
        bus.s_rddata = '0;
        quiet();
        nx();

        // Zero-wait read by m0
        do_reset();
        bus.m0_addr = 19'h4; bus.m0_rdmem = 1'b1;
        nx(); bus.m0_rdmem = 1'b0;
        chk("t1_no_early", 32'(bus.s_rdmem), 32'd0);
        nx();
        chk("t1_s_rdmem", 32'(bus.s_rdmem), 32'd1);
        chk("t1_s_addr", 32'(bus.s_addr), 32'h4);
        nx();
        chk("t1_strobe_1cyc", 32'(bus.s_rdmem), 32'd0);
        bus.s_rddone = 1'b1; bus.s_rddata = 16'h1234;
        nx(); bus.s_rddone = 1'b0;
        chk("t1_rddone", 32'(bus.m0_rddone), 32'd1);
        chk("t1_rddata", 32'(bus.m0_rddata), 32'h1234);
        chk("t1_err", 32'(bus.m0_err), 32'd0);
        chk("t1_m1_quiet", 32'({bus.m1_rddone, bus.m1_rddata}), 32'h0);
        nx();
        chk("t1_done_pulse", 32'(bus.m0_rddone), 32'd0);
        chk("t1_rddata_hold", 32'(bus.m0_rddata), 32'h1234);

        // Both masters write together: m0 first, then m1
        do_reset();
        bus.m0_addr = 19'h10; bus.m0_wrdata = 16'hAAAA; bus.m0_wrmem = 1'b1;
        bus.m1_addr = 19'h20; bus.m1_wrdata = 16'h5555; bus.m1_wrmem = 1'b1;
        nx(); quiet();
        nx();
        chk("t2_m0_wr", 32'({bus.s_wrmem, bus.s_rdmem}), 32'h2);
        chk("t2_m0_addr", 32'(bus.s_addr), 32'h10);
        chk("t2_m0_data", 32'(bus.s_wrdata), 32'hAAAA);
        nx(); bus.s_wrdone = 1'b1;
        chk("t2_gap1", 32'(bus.s_wrmem), 32'd0);
        nx(); quiet();
        chk("t2_m0_done", 32'({bus.m0_wrdone, bus.m1_wrdone}), 32'h2);
        chk("t2_gap2", 32'(bus.s_wrmem), 32'd0);
        nx();
        chk("t2_m1_wr", 32'(bus.s_wrmem), 32'd1);
        chk("t2_m1_addr", 32'(bus.s_addr), 32'h20);
        chk("t2_m1_data", 32'(bus.s_wrdata), 32'h5555);
        nx(); bus.s_wrdone = 1'b1;
        nx(); quiet();
        chk("t2_m1_done", 32'({bus.m0_wrdone, bus.m1_wrdone}), 32'h1);
        // last grant was m1, so a fresh tie goes to m0
        bus.m0_addr = 19'h11; bus.m0_rdmem = 1'b1;
        bus.m1_addr = 19'h21; bus.m1_rdmem = 1'b1;
        nx(); quiet();
        nx();
        chk("t2_rr_addr", 32'(bus.s_addr), 32'h11);
        chk("t2_rr_rd", 32'(bus.s_rdmem), 32'd1);
        nx(); bus.s_rddone = 1'b1; bus.s_rddata = 16'hCAFE;
        nx(); quiet();
        chk("t2_rr_done", 32'({bus.m0_rddone, bus.m1_rddone}), 32'h2);
        chk("t2_rr_data", 32'(bus.m0_rddata), 32'hCAFE);
        chk("t2_m1_rddata0", 32'(bus.m1_rddata), 32'h0);

        // Read+write strobe together becomes a write; wrong-kind ack ignored
        do_reset();
        bus.m0_addr = 19'h30; bus.m0_wrdata = 16'hBEEF;
        bus.m0_rdmem = 1'b1; bus.m0_wrmem = 1'b1;
        nx(); quiet();
        nx();
        chk("t3_kind", 32'({bus.s_wrmem, bus.s_rdmem}), 32'h2);
        chk("t3_data", 32'(bus.s_wrdata), 32'hBEEF);
        nx(); bus.s_rddone = 1'b1; bus.s_rddata = 16'hFFFF;
        nx(); quiet(); bus.s_wrdone = 1'b1;
        chk("t3_mismatch_ack", 32'({bus.m0_wrdone, bus.m0_rddone}), 32'h0);
        nx(); quiet();
        chk("t3_wrdone", 32'({bus.m0_wrdone, bus.m0_rddone, bus.m0_err}), 32'h4);
        chk("t3_rddata", 32'(bus.m0_rddata), 32'h0);
        nx();
        chk("t3_single", 32'(bus.m0_wrdone), 32'd0);

        // m1 read, restrobe on its done cycle, then timeout
        do_reset();
        bus.m1_addr = 19'h7; bus.m1_rdmem = 1'b1;
        nx(); quiet();
        nx();
        nx(); bus.s_rddone = 1'b1; bus.s_rddata = 16'h5A5A;
        nx(); quiet();
        chk("t4_rddone", 32'(bus.m1_rddone), 32'd1);
        chk("t4_rddata", 32'(bus.m1_rddata), 32'h5A5A);
        bus.m1_addr = 19'h8; bus.m1_rdmem = 1'b1;
        nx(); quiet();
        nx();
        chk("t4_reissue", 32'(bus.s_rdmem), 32'd1);
        chk("t4_reissue_addr", 32'(bus.s_addr), 32'h8);
        nx(9);
        chk("t4_not_yet", 32'({bus.m1_rddone, bus.m1_err}), 32'h0);
        chk("t4_addr_hold", 32'(bus.s_addr), 32'h8);
        nx();
        chk("t4_tmo", 32'({bus.m1_rddone, bus.m1_err}), 32'h3);
        chk("t4_tmo_data", 32'(bus.m1_rddata), 32'h0);
        chk("t4_m0_quiet", 32'({bus.m0_rddone, bus.m0_err}), 32'h0);
        nx(); bus.s_rddone = 1'b1; bus.s_rddata = 16'h7777;
        chk("t4_err_pulse", 32'(bus.m1_err), 32'd0);
        chk("t4_idle", 32'(bus.s_rdmem), 32'd0);
        nx(); quiet();
        chk("t4_late_ack", 32'({bus.m1_rddone, bus.m1_rddata}), 32'h0);

        // Reset during WAIT, late ack, strobe during reset dropped
        do_reset();
        bus.m0_addr = 19'h9; bus.m0_rdmem = 1'b1;
        nx(); quiet();
        nx();
        nx();
        rst_n = 1'b0; bus.m1_addr = 19'h55; bus.m1_wrmem = 1'b1;
        nx();
        rst_n = 1'b1; quiet(); bus.s_rddone = 1'b1; bus.s_rddata = 16'hDEAD;
        chk_zero("t5_in_rst");
        nx(); quiet();
        chk("t5_no_done", 32'({bus.m0_rddone, bus.m0_rddata}), 32'h0);
        nx();
        chk("t5_no_issue", 32'({bus.s_rdmem, bus.s_wrmem}), 32'h0);
        nx();
        chk("t5_no_issue2", 32'({bus.s_rdmem, bus.s_wrmem}), 32'h0);

        // m0 restrobes on its wrdone while m1 pending: m1 first, then m0
        do_reset();
        bus.m0_addr = 19'h40; bus.m0_wrdata = 16'h1111; bus.m0_wrmem = 1'b1;
        nx(); quiet();
        bus.m1_addr = 19'h50; bus.m1_wrdata = 16'h2222; bus.m1_wrmem = 1'b1;
        nx(); quiet();
        chk("t6_m0_addr", 32'(bus.s_addr), 32'h40);
        bus.m0_addr = 19'h70; bus.m0_rdmem = 1'b1;
        nx(); quiet(); bus.s_wrdone = 1'b1;
        nx(); quiet();
        chk("t6_m0_done", 32'(bus.m0_wrdone), 32'd1);
        bus.m0_addr = 19'h60; bus.m0_wrdata = 16'h3333; bus.m0_wrmem = 1'b1;
        nx(); quiet();
        chk("t6_m1_addr", 32'(bus.s_addr), 32'h50);
        chk("t6_m1_wr", 32'(bus.s_wrmem), 32'd1);
        nx(); bus.s_wrdone = 1'b1;
        nx(); quiet();
        chk("t6_m1_done", 32'({bus.m0_wrdone, bus.m1_wrdone}), 32'h1);
        nx();
        chk("t6_m0_again", 32'({bus.s_wrmem, bus.s_rdmem}), 32'h2);
        chk("t6_m0_addr2", 32'(bus.s_addr), 32'h60);
        chk("t6_m0_data2", 32'(bus.s_wrdata), 32'h3333);
        nx(); bus.s_wrdone = 1'b1;
        nx(); quiet();
        chk("t6_m0_done2", 32'(bus.m0_wrdone), 32'd1);
        nx(2);
        chk("t6_dropped_rd", 32'({bus.s_rdmem, bus.s_wrmem}), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
